// File: rtl/mul_issue_ctrl.sv
// Operand-preparation and sequencing stage in front of the shift-add multiplier.
// Optional run timeout is compiled in with MUL_ISSUE_TIMEOUT_EN.
module mul_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_lo,
    output logic [31:0] resp_hi,
    output logic        resp_ovf,
    output logic        resp_err,
    output logic        mul_rst,
    output logic        mul_en,
    output logic [63:0] mul_multiplicand,
    output logic [31:0] mul_multiplier,
    input  logic [63:0] mul_accum,
    input  logic        mul_fin
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state, next_state;
    logic        neg;
    logic        sgn;
    logic [63:0] prod;
    logic [31:0] a_mag, b_mag;
    logic [63:0] fix_p;
    logic        fix_ovf;
    logic        timed_out;

`ifdef MUL_ISSUE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] timeout_cnt;
    logic       err_q;

    assign timed_out = (timeout_cnt == TIMEOUT_LIMIT);
    assign resp_err  = err_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
    assign resp_err       = 1'b0;
`endif

    // 0x80000000 negates to itself, which is the correct magnitude when read unsigned.
    assign a_mag   = (req_signed && req_a[31]) ? (~req_a + 32'd1) : req_a;
    assign b_mag   = (req_signed && req_b[31]) ? (~req_b + 32'd1) : req_b;
    assign fix_p   = neg ? (~prod + 64'd1) : prod;
    assign fix_ovf = sgn ? (fix_p[63:32] != {32{fix_p[31]}}) : (|fix_p[63:32]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_valid && req_ready) next_state = RUN;
            RUN: begin
                if (mul_fin)        next_state = FIX;
                else if (timed_out) next_state = DONE;
            end
            FIX:  next_state = DONE;
            DONE: if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs and datapath; mul_rst is held high outside RUN so a stale fin never leaks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_lo          <= '0;
            resp_hi          <= '0;
            resp_ovf         <= 1'b0;
            mul_rst          <= 1'b1;
            mul_en           <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            neg              <= 1'b0;
            sgn              <= 1'b0;
            prod             <= '0;
`ifdef MUL_ISSUE_TIMEOUT_EN
            timeout_cnt      <= '0;
            err_q            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        neg              <= req_signed & (req_a[31] ^ req_b[31]);
                        sgn              <= req_signed;
                        mul_multiplicand <= {32'b0, a_mag};
                        mul_multiplier   <= b_mag;
                        req_ready        <= 1'b0;
                        mul_rst          <= 1'b0;
                        mul_en           <= 1'b1;
`ifdef MUL_ISSUE_TIMEOUT_EN
                        timeout_cnt      <= '0;
`endif
                    end
                end
                RUN: begin
                    if (mul_fin) begin
                        prod    <= mul_accum;
                        mul_en  <= 1'b0;
                        mul_rst <= 1'b1;
                    end else if (timed_out) begin
                        mul_en     <= 1'b0;
                        mul_rst    <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_lo    <= '0;
                        resp_hi    <= '0;
                        resp_ovf   <= 1'b0;
`ifdef MUL_ISSUE_TIMEOUT_EN
                        err_q      <= 1'b1;
`endif
                    end
`ifdef MUL_ISSUE_TIMEOUT_EN
                    timeout_cnt <= timeout_cnt + 8'd1;
`endif
                end
                FIX: begin
                    resp_lo    <= fix_p[31:0];
                    resp_hi    <= fix_p[63:32];
                    resp_ovf   <= fix_ovf;
                    resp_valid <= 1'b1;
`ifdef MUL_ISSUE_TIMEOUT_EN
                    err_q      <= 1'b0;
`endif
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
`ifdef MUL_ISSUE_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
